// File: rtl/module_receiver_fifo_if.sv
// Handshake and read-port bundle for module_receiver_fifo.
// The source/consumer side takes the master modport; the receiver takes slave.
interface module_receiver_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32
);
    logic                    Req;
    logic [DATA_WIDTH-1:0]   Entrada;
    logic                    Ack;
    logic                    RdEn;
    logic                    Clear;
    logic [DATA_WIDTH-1:0]   DataOut;
    logic                    Empty;
    logic                    Full;
    logic [$clog2(DEPTH):0]  Count;
    logic                    Stall;

    modport master (
        output Req, Entrada, RdEn, Clear,
        input  Ack, DataOut, Empty, Full, Count, Stall
    );

    modport slave (
        input  Req, Entrada, RdEn, Clear,
        output Ack, DataOut, Empty, Full, Count, Stall
    );
endinterface

// File: rtl/module_receiver_fifo.sv
// Four-phase Req/Ack receiver feeding a circular buffer with a registered
// read port. Req is synchronised; Entrada is bundled data and is sampled
// directly once the synchronised Req is seen. A full buffer withholds Ack
// until a slot frees up, so no word is lost.
module module_receiver_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input logic                   Clock,
    input logic                   Reset,
    module_receiver_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  req_sync;
    logic                    req_s;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    full, empty;
    logic                    wr_fire, rd_fire;

    assign req_s   = req_sync[SYNC_STAGES-1];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A read on a non-empty buffer; when full it frees the slot the stalled write needs.
    assign rd_fire = bus.RdEn && !empty;

    // Shift the asynchronous Req through the synchroniser chain.
    always_ff @(posedge Clock) begin
        if (!Reset) req_sync <= '0;
        else        req_sync <= {req_sync[SYNC_STAGES-2:0], bus.Req};
    end

    // Handshake state register.
    always_ff @(posedge Clock) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and write decision; a write is allowed when a slot is free now.
    always_comb begin
        state_next = state;
        wr_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && (!full || rd_fire)) begin
                    wr_fire    = 1'b1;
                    state_next = ACKED;
                end
            end
            ACKED: begin
                if (!req_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage array; Clear discards a coincident write, contents are never reset.
    always_ff @(posedge Clock) begin
        if (wr_fire && !bus.Clear) mem[wr_ptr] <= bus.Entrada;
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (bus.Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            if (wr_fire && !rd_fire)      count <= count + 1'b1;
            else if (rd_fire && !wr_fire) count <= count - 1'b1;
        end
    end

    assign bus.Ack     = (state == ACKED);
    assign bus.DataOut = dout;
    assign bus.Count   = count;
    assign bus.Empty   = empty;
    assign bus.Full    = full;
    assign bus.Stall   = req_s && (state == IDLE) && full;

endmodule

// File: tb/tb_module_receiver_fifo.sv
// Directed bench for module_receiver_fifo: a default-sized instance and a
// DEPTH=4 instance, driven by a vector table plus hand-written sequences.
module tb_module_receiver_fifo;

    logic clk;
    logic rst_a, rst_b;
    int   nvec = 0;
    int   nmis = 0;
    logic [15:0] last_b;

    module_receiver_fifo_if #(.DATA_WIDTH(16), .DEPTH(32)) ia ();
    module_receiver_fifo_if #(.DATA_WIDTH(16), .DEPTH(4))  ib ();

    module_receiver_fifo #(.DATA_WIDTH(16), .DEPTH(32), .SYNC_STAGES(2)) ua (
        .Clock (clk),
        .Reset (rst_a),
        .bus   (ia.slave)
    );

    module_receiver_fifo #(.DATA_WIDTH(16), .DEPTH(4), .SYNC_STAGES(2)) ub (
        .Clock (clk),
        .Reset (rst_b),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        rden;
        logic        clr;
        logic [15:0] din;
        logic        ack;
        logic [15:0] dout;
        logic [2:0]  cnt;
        logic        emp;
        logic        full;
        logic        stall;
    } vec_t;

    vec_t vt [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_a(input logic [15:0] w);
        ia.Req = 1'b1;
        ia.Entrada = w;
        tick(); tick();
        check("a_ack_early", 32'(ia.Ack), 32'd0);
        tick();
        check("a_ack_rise", 32'(ia.Ack), 32'd1);
        ia.Req = 1'b0;
        tick(); tick(); tick();
        check("a_ack_fall", 32'(ia.Ack), 32'd0);
    endtask

    task automatic send_b(input logic [15:0] w);
        ib.Req = 1'b1;
        ib.Entrada = w;
        tick(); tick();
        check("b_ack_early", 32'(ib.Ack), 32'd0);
        tick();
        check("b_ack_rise", 32'(ib.Ack), 32'd1);
        ib.Req = 1'b0;
        tick(); tick(); tick();
        check("b_ack_fall", 32'(ib.Ack), 32'd0);
    endtask

    task automatic read_b(input logic [15:0] exp);
        ib.RdEn = 1'b1;
        tick();
        ib.RdEn = 1'b0;
        check("b_dout", 32'(ib.DataOut), 32'(exp));
        last_b = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // Table: DEPTH=4 instance from reset; read-on-empty, one handshake, reads.
        vt[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 16'hA1A1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 16'hA1A1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 16'hA1A1, 1'b1, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 16'hA1A1, 1'b1, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 16'hA1A1, 1'b1, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 16'hA1A1, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hA1A1, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hA1A1, 3'd0, 1'b1, 1'b0, 1'b0};

        ia.Req = 1'b0; ia.Entrada = '0; ia.RdEn = 1'b0; ia.Clear = 1'b0;
        ib.Req = 1'b0; ib.Entrada = '0; ib.RdEn = 1'b0; ib.Clear = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        last_b = 16'h0000;
        tick(); tick();

        // Reset state of both instances.
        check("a_rst_ack",   32'(ia.Ack),     32'd0);
        check("a_rst_dout",  32'(ia.DataOut), 32'd0);
        check("a_rst_count", 32'(ia.Count),   32'd0);
        check("a_rst_empty", 32'(ia.Empty),   32'd1);
        check("a_rst_full",  32'(ia.Full),    32'd0);
        check("a_rst_stall", 32'(ia.Stall),   32'd0);
        check("b_rst_count", 32'(ib.Count),   32'd0);
        check("b_rst_empty", 32'(ib.Empty),   32'd1);
        rst_a = 1'b1; rst_b = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            ib.Req = vt[i].req;
            ib.RdEn = vt[i].rden;
            ib.Clear = vt[i].clr;
            ib.Entrada = vt[i].din;
            tick();
            check($sformatf("vec%0d_ack", i),   32'(ib.Ack),     32'(vt[i].ack));
            check($sformatf("vec%0d_dout", i),  32'(ib.DataOut), 32'(vt[i].dout));
            check($sformatf("vec%0d_count", i), 32'(ib.Count),   32'(vt[i].cnt));
            check($sformatf("vec%0d_empty", i), 32'(ib.Empty),   32'(vt[i].emp));
            check($sformatf("vec%0d_full", i),  32'(ib.Full),    32'(vt[i].full));
            check($sformatf("vec%0d_stall", i), 32'(ib.Stall),   32'(vt[i].stall));
        end
        ib.RdEn = 1'b0;
        last_b = 16'hA1A1;

        // Default instance: 17 words in, 17 words out in order.
        for (int i = 0; i < 17; i++) send_a(16'h3000 + 16'(i));
        check("a_count17", 32'(ia.Count), 32'd17);
        for (int i = 0; i < 17; i++) begin
            ia.RdEn = 1'b1;
            tick();
            ia.RdEn = 1'b0;
            check("a_dout",  32'(ia.DataOut), 32'(16'h3000 + 16'(i)));
            check("a_count", 32'(ia.Count),   32'(16 - i));
        end
        check("a_empty_end", 32'(ia.Empty), 32'd1);

        // DEPTH=4: fill, stall the fifth word, release it with one read.
        for (int i = 0; i < 4; i++) send_b(16'h4000 + 16'(i));
        check("b_full4",  32'(ib.Full),  32'd1);
        check("b_count4", 32'(ib.Count), 32'd4);
        ib.Req = 1'b1;
        ib.Entrada = 16'h4004;
        tick(); tick(); tick();
        check("b_stall",       32'(ib.Stall), 32'd1);
        check("b_stall_noack", 32'(ib.Ack),   32'd0);
        check("b_stall_count", 32'(ib.Count), 32'd4);
        ib.RdEn = 1'b1;
        tick();
        ib.RdEn = 1'b0;
        check("b_rel_dout",  32'(ib.DataOut), 32'h4000);
        check("b_rel_ack",   32'(ib.Ack),     32'd1);
        check("b_rel_count", 32'(ib.Count),   32'd4);
        check("b_rel_full",  32'(ib.Full),    32'd1);
        check("b_rel_stall", 32'(ib.Stall),   32'd0);
        ib.Req = 1'b0;
        tick(); tick(); tick();
        check("b_rel_ackfall", 32'(ib.Ack), 32'd0);
        for (int i = 1; i < 5; i++) read_b(16'h4000 + 16'(i));
        check("b_drain_empty", 32'(ib.Empty), 32'd1);

        // DEPTH=4: interleaved traffic wrapping the pointers several times.
        for (int i = 0; i < 10; i++) begin
            send_b(16'h5100 + 16'(i));
            read_b(16'h5100 + 16'(i));
        end
        check("b_wrap_count", 32'(ib.Count), 32'd0);

        // Reset while Ack is high with two words stored.
        send_b(16'h6001);
        ib.Req = 1'b1;
        ib.Entrada = 16'h6002;
        tick(); tick(); tick();
        check("b_pre_rst_ack",   32'(ib.Ack),   32'd1);
        check("b_pre_rst_count", 32'(ib.Count), 32'd2);
        rst_b = 1'b0;
        ib.Req = 1'b0;
        tick();
        check("b_mid_rst_ack",   32'(ib.Ack),     32'd0);
        check("b_mid_rst_count", 32'(ib.Count),   32'd0);
        check("b_mid_rst_empty", 32'(ib.Empty),   32'd1);
        check("b_mid_rst_dout",  32'(ib.DataOut), 32'd0);
        rst_b = 1'b1;
        tick(); tick(); tick();
        send_b(16'h5A5A);
        read_b(16'h5A5A);

        // Clear coincident with the write of 16'hBEEF while Count=3.
        send_b(16'hC001);
        send_b(16'hC002);
        send_b(16'hC003);
        check("b_clr_pre_count", 32'(ib.Count), 32'd3);
        ib.Req = 1'b1;
        ib.Entrada = 16'hBEEF;
        tick(); tick();
        ib.Clear = 1'b1;
        tick();
        ib.Clear = 1'b0;
        check("b_clr_ack",   32'(ib.Ack),   32'd1);
        check("b_clr_count", 32'(ib.Count), 32'd0);
        check("b_clr_empty", 32'(ib.Empty), 32'd1);
        ib.Req = 1'b0;
        tick(); tick(); tick();
        check("b_clr_ackfall", 32'(ib.Ack), 32'd0);
        ib.RdEn = 1'b1;
        tick();
        ib.RdEn = 1'b0;
        check("b_clr_rd_dout",  32'(ib.DataOut), 32'(last_b));
        check("b_clr_rd_count", 32'(ib.Count),   32'd0);
        check("b_clr_rd_empty", 32'(ib.Empty),   32'd1);
        send_b(16'h1234);
        read_b(16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/module_receiver_fifo.md
# module_receiver_fifo

Parametrised successor to the single-word handshake receiver. It accepts words on a four-phase Req/Ack handshake from an asynchronous or slower source and synchronises Req internally. Received words are stored in an internal circular buffer of configurable width and depth, and a local consumer drains them through a registered read port. When the buffer is full the block applies backpressure by withholding Ack, so no word is ever dropped.

## Interface
- DATA_WIDTH, 16, width of Entrada and DataOut
- DEPTH, 32, buffer depth in words; power of two, ≥ 2
- SYNC_STAGES, 2, flip-flop stages on Req; legal values 2 or 3
- Clock  in  1  single system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- Req  in  1  source request, four-phase; asynchronous to Clock
- Entrada  in  DATA_WIDTH  data from source; stable whenever Req is high
- Ack  out  1  acknowledge to source
- RdEn  in  1  consumer read strobe
- Clear  in  1  synchronous buffer flush, active-high
- DataOut  out  DATA_WIDTH  registered read data
- Empty  out  1  buffer holds 0 words
- Full  out  1  buffer holds DEPTH words
- Count  out  $clog2(DEPTH)+1  words currently stored
- Stall  out  1  synchronised Req is high, FSM is in IDLE, and the buffer is full

## Operation
- Req passes through SYNC_STAGES flops, giving ReqS. Entrada is sampled unsynchronised, which is legal under bundled-data rules.
- FSM states: IDLE and ACKED.
  - IDLE, Ack=0: if ReqS=1 and the buffer is not full, write Entrada to mem[wr_ptr], increment wr_ptr modulo DEPTH, and go to ACKED.
  - IDLE with ReqS=1 and the buffer full: stay in IDLE with Stall=1. The word is written on the first cycle a slot is free.
  - ACKED, Ack=1: wait for ReqS=0, then go to IDLE. Exactly one word is written per Req pulse.
- Read: RdEn=1 and Empty=0 loads DataOut ← mem[rd_ptr] and increments rd_ptr modulo DEPTH.
  - RdEn while Empty is ignored. DataOut holds and the pointers do not move.
- Count:
  - +1 on a write only, −1 on a read only.
  - Unchanged on a simultaneous write and read, including when full. When full, the read frees the slot in the same cycle that the pending write uses it.
- Empty = (Count==0). Full = (Count==DEPTH). Both are derived from registered Count.
- Clear=1:
  - Sets pointers and Count to 0 and Empty to 1.
  - The FSM state, Ack, and DataOut are unaffected.
  - Clear has priority over any read or write in the same cycle; that write is discarded, but the FSM still advances to ACKED.
- Reset=0 at a rising edge:
  - FSM goes to IDLE; sync flops, pointers, and Count are cleared.
  - Outputs: Ack=0, DataOut=0, Count=0, Empty=1, Full=0, Stall=0.
  - A handshake in progress is abandoned. The source sees Ack fall, and the word is kept only if it was already written.
- Memory contents are not reset.

## Timing
- Ack rise latency: Req high before edge E0 means ReqS is high after edge E(SYNC_STAGES−1), and the write plus Ack=1 happen at edge E(SYNC_STAGES). For SYNC_STAGES=2, Ack rises 3 edges after Req, provided the buffer is not full.
- Ack fall latency: the same number of edges (SYNC_STAGES+1) after Req falls.
- Minimum handshake period: 2·(SYNC_STAGES+1) cycles.
- Read latency: DataOut is valid at the edge where RdEn is sampled, i.e. visible in the following cycle.
- Count, Empty, and Full update at the same edge as the write or read.
- Stall is combinational from registered state and needs no extra register.
- Full-to-write latency: a read at edge E allows a pending stalled write at the same edge E.
- Word order is strictly FIFO across pointer wrap-around.

## Test plan
- Defaults. Send 17 words 16'h3000–16'h3010 via Req/Ack, then read 17 times → DataOut is 3000…3010 in order, Count goes 17→0, Empty=1 at the end, and Ack rises 3 edges after each Req.
- DEPTH=4. Send 5 words without reading → Full=1 after the 4th; for the 5th, Stall=1 and Ack stays 0. One RdEn → DataOut=1st word, the 5th word is written at the same edge, Ack rises, and Count stays 4.
- DEPTH=4, wrap-around. Interleave 10 writes and reads with Count held ≤ 3 → output sequence equals input sequence, and the pointers wrap twice without error.
- Read on empty. After reset, pulse RdEn 3 times → DataOut stays 0, Count stays 0, and Empty stays 1.
- Reset mid-handshake. Drop Reset while Ack=1 and Count=2 → at the next edge Ack=0, Count=0, Empty=1, DataOut=0. After Reset returns high, a new Req is accepted normally.
- Clear. With Count=3, assert Clear in the same cycle as the write of word 16'hBEEF → Count=0 and Empty=1, the word is discarded, Ack still completes, and a subsequent read is ignored.
